// File: rtl/icache_fill_unit.sv
// rtl/icache_fill_unit.sv - direct-mapped instruction cache with 8-word line miss-fill FSM
module icache_fill_unit #(
    parameter int LINE_WORDS  = 8,
    parameter int NUM_LINES   = 64,
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] fetch_addr,
    input  logic        fetch_req,
    output logic [15:0] instr_out,
    output logic        stall,
    output logic        mem_en,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data_in,
    input  logic        mem_data_valid
);

    // Address split is hard-wired (offset [3:1], index [9:4], tag [15:10]);
    // the fill logic does not depend on latency since words return in order.
    if (LINE_WORDS != 8 || NUM_LINES != 64 || MEM_LATENCY < 1) begin : g_bad_params
        $error("icache_fill_unit: unsupported geometry");
    end

    typedef enum logic {
        S_IDLE,
        S_FILL
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] miss_line_q, miss_line_d;
    logic [3:0]  issue_cnt_q, issue_cnt_d;
    logic [2:0]  recv_cnt_q, recv_cnt_d;
    logic [NUM_LINES-1:0] valid_q;

    logic [5:0]  tag_q  [NUM_LINES];
    logic [15:0] data_q [NUM_LINES*LINE_WORDS];

    logic [5:0]  idx;
    logic [2:0]  off;
    logic        hit;
    logic        stall_int;
    logic        mem_en_int;
    logic [15:0] mem_addr_int;
    logic        fill_wr;
    logic        fill_done;
    logic        unused_addr_bit;

    assign idx             = fetch_addr[9:4];
    assign off             = fetch_addr[3:1];
    assign unused_addr_bit = fetch_addr[0];

    // Zero-latency lookup: a miss returns zero so stale data never leaks.
    always_comb begin
        hit       = valid_q[idx] && (tag_q[idx] == fetch_addr[15:10]);
        instr_out = 16'h0000;
        if (hit) begin
            instr_out = data_q[{idx, off}];
        end
    end

    // Next-state and outputs: detect a miss in IDLE, issue and collect the line in FILL.
    always_comb begin
        state_d      = state_q;
        miss_line_d  = miss_line_q;
        issue_cnt_d  = issue_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        stall_int    = 1'b0;
        mem_en_int   = 1'b0;
        mem_addr_int = 16'h0000;
        fill_wr      = 1'b0;
        fill_done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fetch_req && !hit) begin
                    stall_int   = 1'b1;
                    miss_line_d = fetch_addr[15:4];
                    issue_cnt_d = 4'd0;
                    recv_cnt_d  = 3'd0;
                    state_d     = S_FILL;
                end
            end
            S_FILL: begin
                stall_int = 1'b1;
                // issue_cnt reaches 8 after the last request; bit 3 marks "all issued"
                if (!issue_cnt_q[3]) begin
                    mem_en_int   = 1'b1;
                    mem_addr_int = {miss_line_q, issue_cnt_q[2:0], 1'b0};
                    issue_cnt_d  = issue_cnt_q + 4'd1;
                end
                if (mem_data_valid) begin
                    fill_wr    = 1'b1;
                    recv_cnt_d = recv_cnt_q + 3'd1;
                    if (recv_cnt_q == 3'd7) begin
                        fill_done = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset must silence the memory interface even before the edge lands.
    assign stall    = rst_n & stall_int;
    assign mem_en   = rst_n & mem_en_int;
    assign mem_addr = rst_n ? mem_addr_int : 16'h0000;

    // Control state and valid bits; a line becomes valid only with its 8th word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            miss_line_q <= 12'h000;
            issue_cnt_q <= 4'd0;
            recv_cnt_q  <= 3'd0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_line_q <= miss_line_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            if (fill_done) begin
                valid_q[miss_line_q[5:0]] <= 1'b1;
            end
        end
    end

    // Data and tag storage carry no reset; the valid bits alone gate hits.
    always_ff @(posedge clk) begin
        if (rst_n && fill_wr) begin
            data_q[{miss_line_q[5:0], recv_cnt_q}] <= mem_data_in;
        end
        if (rst_n && fill_done) begin
            tag_q[miss_line_q[5:0]] <= miss_line_q[11:6];
        end
    end

endmodule
